// File: rtl/gshare_bpred_if.sv
// Fetch/AGEX-facing bus of the gshare branch predictor.
// slave  : predictor side (takes lookup PC and resolved updates, returns prediction + stats).
// master : pipeline side (drives lookup PC and updates, consumes prediction + stats).
// Signals:
//   lookup_pc_i                 fetch PC
//   pred_taken_o, btb_hit_o     prediction flags
//   pred_target_o               predicted target (0 on miss)
//   bhr_o, pht_index_o,         prediction-time metadata carried down the pipe
//   pht_entry_o, btb_index_o
//   upd_*                       resolved control-flow outcome from AGEX
//   stat_upd_cnt_o, stat_mispred_cnt_o  performance counters
interface gshare_bpred_if #(
  parameter int unsigned DBITS    = 32,
  parameter int unsigned BHR_BITS = 8,
  parameter int unsigned PHT_BITS = 8,
  parameter int unsigned BTB_BITS = 4,
  parameter int unsigned CNT_BITS = 32
);
  logic [DBITS-1:0]    lookup_pc_i;
  logic                pred_taken_o;
  logic                btb_hit_o;
  logic [DBITS-1:0]    pred_target_o;
  logic [BHR_BITS-1:0] bhr_o;
  logic [PHT_BITS-1:0] pht_index_o;
  logic [1:0]          pht_entry_o;
  logic [BTB_BITS-1:0] btb_index_o;

  logic                upd_valid_i;
  logic                upd_is_br_i;
  logic [DBITS-1:0]    upd_pc_i;
  logic                upd_taken_i;
  logic [DBITS-1:0]    upd_target_i;
  logic [PHT_BITS-1:0] upd_pht_index_i;
  logic                upd_mispred_i;

  logic [CNT_BITS-1:0] stat_upd_cnt_o;
  logic [CNT_BITS-1:0] stat_mispred_cnt_o;

  modport master (
    output lookup_pc_i,
    input  pred_taken_o, btb_hit_o, pred_target_o, bhr_o, pht_index_o, pht_entry_o, btb_index_o,
    output upd_valid_i, upd_is_br_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pht_index_i,
    output upd_mispred_i,
    input  stat_upd_cnt_o, stat_mispred_cnt_o
  );

  modport slave (
    input  lookup_pc_i,
    output pred_taken_o, btb_hit_o, pred_target_o, bhr_o, pht_index_o, pht_entry_o, btb_index_o,
    input  upd_valid_i, upd_is_br_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pht_index_i,
    input  upd_mispred_i,
    output stat_upd_cnt_o, stat_mispred_cnt_o
  );
endinterface

// File: rtl/gshare_bpred.sv
// Gshare/bimodal/global direction predictor with a direct-mapped BTB.
// Lookup is combinational from bp.lookup_pc_i and current state; updates from AGEX train the
// PHT, BHR and BTB at the clock edge. Reads always see pre-update state (read-before-write).
// Ports:
//   clk    clock
//   reset  synchronous, active-high; clears PHT to weakly-not-taken, BHR, BTB valids, counters
//   bp     predictor-side bus (see gshare_bpred_if)
module gshare_bpred #(
  parameter int unsigned DBITS      = 32,
  parameter int unsigned BHR_BITS   = 8,
  parameter int unsigned PHT_BITS   = 8,
  parameter int unsigned BTB_BITS   = 4,
  parameter int unsigned INDEX_MODE = 0,
  parameter int unsigned CNT_BITS   = 32
) (
  input  logic          clk,
  input  logic          reset,
  gshare_bpred_if.slave bp
);

  localparam int unsigned PhtEntries = 2 ** PHT_BITS;
  localparam int unsigned BtbEntries = 2 ** BTB_BITS;
  localparam int unsigned TagBits    = DBITS - BTB_BITS - 2;

  // State
  logic [1:0]            pht_q [PhtEntries];
  logic [1:0]            pht_d [PhtEntries];
  logic [BHR_BITS-1:0]   bhr_q, bhr_d;
  logic [BtbEntries-1:0] btb_valid_q, btb_valid_d;
  logic [CNT_BITS-1:0]   upd_cnt_q, upd_cnt_d;
  logic [CNT_BITS-1:0]   mis_cnt_q, mis_cnt_d;

  // BTB payload needs no reset: it is only ever observed through a valid bit
  logic                  btb_jmp_q [BtbEntries];
  logic [TagBits-1:0]    btb_tag_q [BtbEntries];
  logic [DBITS-1:0]      btb_tgt_q [BtbEntries];

  // Lookup
  logic [PHT_BITS-1:0]   lk_pht_idx;
  logic [BTB_BITS-1:0]   lk_btb_idx;
  logic [TagBits-1:0]    lk_tag;
  logic                  lk_hit;

  // Update decode
  logic [BTB_BITS-1:0]   up_btb_idx;
  logic [TagBits-1:0]    up_tag;
  logic                  up_br;
  logic                  up_btb_wr;
  logic [1:0]            up_ctr;

  logic                  unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp.lookup_pc_i[1:0], bp.upd_pc_i[1:0]};

  always_comb begin
    lk_btb_idx = bp.lookup_pc_i[BTB_BITS+1:2];
    lk_tag     = bp.lookup_pc_i[DBITS-1:BTB_BITS+2];
    if (INDEX_MODE == 1) begin
      lk_pht_idx = bp.lookup_pc_i[PHT_BITS+1:2];
    end else if (INDEX_MODE == 2) begin
      lk_pht_idx = PHT_BITS'(bhr_q);
    end else begin
      lk_pht_idx = bp.lookup_pc_i[PHT_BITS+1:2] ^ PHT_BITS'(bhr_q);
    end
    lk_hit = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
  end

  assign bp.btb_hit_o     = lk_hit;
  assign bp.pred_target_o = lk_hit ? btb_tgt_q[lk_btb_idx] : '0;
  assign bp.pred_taken_o  = lk_hit && (btb_jmp_q[lk_btb_idx] || pht_q[lk_pht_idx][1]);
  assign bp.bhr_o         = bhr_q;
  assign bp.pht_index_o   = lk_pht_idx;
  assign bp.pht_entry_o   = pht_q[lk_pht_idx];
  assign bp.btb_index_o   = lk_btb_idx;

  assign bp.stat_upd_cnt_o     = upd_cnt_q;
  assign bp.stat_mispred_cnt_o = mis_cnt_q;

  // Next state
  always_comb begin
    up_btb_idx  = bp.upd_pc_i[BTB_BITS+1:2];
    up_tag      = bp.upd_pc_i[DBITS-1:BTB_BITS+2];
    up_br       = bp.upd_valid_i && bp.upd_is_br_i;
    // Jumps always install; branches only when taken
    up_btb_wr   = bp.upd_valid_i && (!bp.upd_is_br_i || bp.upd_taken_i);
    up_ctr      = pht_q[bp.upd_pht_index_i];

    pht_d       = pht_q;
    bhr_d       = bhr_q;
    btb_valid_d = btb_valid_q;
    upd_cnt_d   = upd_cnt_q;
    mis_cnt_d   = mis_cnt_q;

    if (up_br) begin
      if (bp.upd_taken_i && (up_ctr != 2'b11)) begin
        pht_d[bp.upd_pht_index_i] = up_ctr + 2'd1;
      end else if (!bp.upd_taken_i && (up_ctr != 2'b00)) begin
        pht_d[bp.upd_pht_index_i] = up_ctr - 2'd1;
      end
      // Truncating the concatenation keeps {bhr[BHR_BITS-2:0], taken}, and just taken for 1 bit
      bhr_d = BHR_BITS'({bhr_q, bp.upd_taken_i});
    end

    if (up_btb_wr) begin
      btb_valid_d[up_btb_idx] = 1'b1;
    end

    if (bp.upd_valid_i) begin
      upd_cnt_d = upd_cnt_q + CNT_BITS'(1);
      if (bp.upd_mispred_i) begin
        mis_cnt_d = mis_cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PhtEntries; i++) begin
        pht_q[i] <= 2'b01;
      end
      bhr_q       <= '0;
      btb_valid_q <= '0;
      upd_cnt_q   <= '0;
      mis_cnt_q   <= '0;
    end else begin
      pht_q       <= pht_d;
      bhr_q       <= bhr_d;
      btb_valid_q <= btb_valid_d;
      upd_cnt_q   <= upd_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  // A write landing during reset is harmless: its valid bit is cleared in the same edge
  always_ff @(posedge clk) begin
    if (up_btb_wr) begin
      btb_jmp_q[up_btb_idx] <= !bp.upd_is_br_i;
      btb_tag_q[up_btb_idx] <= up_tag;
      btb_tgt_q[up_btb_idx] <= bp.upd_target_i;
    end
  end

endmodule

// File: tb/tb_gshare_bpred.sv
// Self-checking bench for gshare_bpred (default parameters, gshare mode).
module tb_gshare_bpred;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gshare_bpred_if bus ();

  gshare_bpred dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state, kept as plain arrays of integers
  int unsigned m_pht  [256];
  int unsigned m_bhr;
  bit          m_bv   [16];
  bit          m_bj   [16];
  int unsigned m_btag [16];
  int unsigned m_btgt [16];
  int unsigned m_upd;
  int unsigned m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the reference every cycle, then advance the reference with the
  // inputs the DUT will capture at the coming posedge.
  initial begin
    int unsigned pc, pidx, bidx, tag, ui, ub;
    bit hit;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) begin
      m_bv[i] = 0; m_bj[i] = 0; m_btag[i] = 0; m_btgt[i] = 0;
    end
    m_bhr = 0; m_upd = 0; m_mis = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        pc   = bus.lookup_pc_i;
        pidx = ((pc >> 2) ^ m_bhr) % 256;
        bidx = (pc >> 2) % 16;
        tag  = pc >> 6;
        hit  = m_bv[bidx] && (m_btag[bidx] == tag);
        check("m_hit",    32'(bus.btb_hit_o),    32'(hit));
        check("m_target", bus.pred_target_o,     hit ? m_btgt[bidx] : 0);
        check("m_taken",  32'(bus.pred_taken_o), 32'(hit && (m_bj[bidx] || m_pht[pidx] >= 2)));
        check("m_bhr",    32'(bus.bhr_o),        m_bhr);
        check("m_pidx",   32'(bus.pht_index_o),  pidx);
        check("m_pent",   32'(bus.pht_entry_o),  m_pht[pidx]);
        check("m_bidx",   32'(bus.btb_index_o),  bidx);
        check("m_updcnt", bus.stat_upd_cnt_o,    m_upd);
        check("m_miscnt", bus.stat_mispred_cnt_o, m_mis);
      end
      if (reset === 1'b1) begin
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 0;
        m_bhr = 0; m_upd = 0; m_mis = 0;
      end else if (bus.upd_valid_i === 1'b1) begin
        m_upd++;
        if (bus.upd_mispred_i) m_mis++;
        ui = bus.upd_pht_index_i;
        ub = (bus.upd_pc_i >> 2) % 16;
        if (bus.upd_is_br_i) begin
          if (bus.upd_taken_i) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
          else                 m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
          m_bhr = ((m_bhr << 1) | 32'(bus.upd_taken_i)) % 256;
        end
        if (!bus.upd_is_br_i || bus.upd_taken_i) begin
          m_bv[ub]   = 1;
          m_bj[ub]   = !bus.upd_is_br_i;
          m_btag[ub] = bus.upd_pc_i >> 6;
          m_btgt[ub] = bus.upd_target_i;
        end
      end
    end
  end

  task automatic upd(input bit is_br, input logic [31:0] pc, input bit taken,
                     input logic [31:0] target, input logic [7:0] idx, input bit mis);
    @(posedge clk); #1;
    bus.upd_valid_i     = 1'b1;
    bus.upd_is_br_i     = is_br;
    bus.upd_pc_i        = pc;
    bus.upd_taken_i     = taken;
    bus.upd_target_i    = target;
    bus.upd_pht_index_i = idx;
    bus.upd_mispred_i   = mis;
    @(posedge clk); #1;
    bus.upd_valid_i     = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    @(posedge clk); #2;
    bus.lookup_pc_i = pc;
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    bus.lookup_pc_i     = 32'h100;
    bus.upd_valid_i     = 1'b0;
    bus.upd_is_br_i     = 1'b0;
    bus.upd_pc_i        = '0;
    bus.upd_taken_i     = 1'b0;
    bus.upd_target_i    = '0;
    bus.upd_pht_index_i = '0;
    bus.upd_mispred_i   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset state
    check("rst_hit",    32'(bus.btb_hit_o),    0);
    check("rst_taken",  32'(bus.pred_taken_o), 0);
    check("rst_target", bus.pred_target_o,     0);
    check("rst_pent",   32'(bus.pht_entry_o),  1);
    check("rst_bhr",    32'(bus.bhr_o),        0);
    reset = 1'b0;

    // First taken branch trains BTB, BHR and PHT[0x40]
    upd(1, 32'h100, 1, 32'h200, 8'h40, 0);
    look(32'h100);
    check("t1_hit",    32'(bus.btb_hit_o),   1);
    check("t1_target", bus.pred_target_o,    32'h200);
    check("t1_bhr",    32'(bus.bhr_o),       1);
    check("t1_pidx",   32'(bus.pht_index_o), 32'h41);
    look(32'h104);  // (0x41 ^ 0x01) selects counter 0x40
    check("t1_ctr40",  32'(bus.pht_entry_o), 2);

    // Saturate up, then down
    for (int i = 0; i < 3; i++) upd(1, 32'h100, 1, 32'h200, 8'h40, 0);
    look(32'h13C);  // 0x4F ^ 0x0F
    check("sat_hi_pidx", 32'(bus.pht_index_o), 32'h40);
    check("sat_hi",      32'(bus.pht_entry_o), 3);
    for (int i = 0; i < 5; i++) upd(1, 32'h100, 0, 32'h999, 8'h40, 0);
    look(32'h280);  // 0xA0 ^ 0xE0
    check("sat_lo_pidx", 32'(bus.pht_index_o), 32'h40);
    check("sat_lo",      32'(bus.pht_entry_o), 0);
    look(32'h100);  // not-taken updates leave the BTB alone
    check("nt_keep_hit", 32'(bus.btb_hit_o),   1);

    // Unconditional jump predicts taken regardless of a not-taken counter
    upd(0, 32'h300, 1, 32'h80, 8'h00, 0);
    look(32'h300);
    check("jmp_taken",  32'(bus.pred_taken_o), 1);
    check("jmp_target", bus.pred_target_o,     32'h80);
    check("jmp_bhr",    32'(bus.bhr_o),        32'hE0);
    check("jmp_pent",   32'(bus.pht_entry_o),  1);
    look(32'h100);  // same BTB index 0, evicted
    check("jmp_evict",  32'(bus.btb_hit_o),    0);

    // Direct-mapped conflict at index 1
    upd(1, 32'h004, 1, 32'h111, 8'h00, 0);
    upd(1, 32'h044, 1, 32'h222, 8'h00, 0);
    look(32'h004);
    check("conf_old", 32'(bus.btb_hit_o), 0);
    look(32'h044);
    check("conf_new", 32'(bus.btb_hit_o), 1);
    check("conf_tgt", bus.pred_target_o,  32'h222);
    check("conf_bhr", 32'(bus.bhr_o),     32'h83);

    // Same-cycle lookup and write: old view now, new view next cycle
    @(posedge clk); #1;
    bus.lookup_pc_i  = 32'h500;
    bus.upd_valid_i  = 1'b1;
    bus.upd_is_br_i  = 1'b0;
    bus.upd_pc_i     = 32'h500;
    bus.upd_taken_i  = 1'b1;
    bus.upd_target_i = 32'h600;
    #1;
    check("rbw_old_hit", 32'(bus.btb_hit_o), 0);
    @(posedge clk); #1;
    bus.upd_valid_i  = 1'b0;
    #1;
    check("rbw_new_hit", 32'(bus.btb_hit_o), 1);
    check("rbw_new_tgt", bus.pred_target_o,  32'h600);

    // Counters, then reset colliding with an update
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 10; i++) upd(1, 32'h044, 1, 32'h222, 8'(i), (i % 3) == 0 && i < 9);
    look(32'h044);
    check("stat_upd", bus.stat_upd_cnt_o,     10);
    check("stat_mis", bus.stat_mispred_cnt_o, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.upd_valid_i = 1'b1; bus.upd_is_br_i = 1'b1; bus.upd_pc_i = 32'h044;
    bus.upd_taken_i = 1'b1; bus.upd_mispred_i = 1'b1; bus.upd_pht_index_i = 8'h11;
    @(posedge clk); #1;
    reset = 1'b0; bus.upd_valid_i = 1'b0; bus.upd_mispred_i = 1'b0;
    #1;
    check("clr_upd", bus.stat_upd_cnt_o,     0);
    check("clr_mis", bus.stat_mispred_cnt_o, 0);
    check("clr_hit", 32'(bus.btb_hit_o),     0);
    check("clr_bhr", 32'(bus.bhr_o),         0);
    check("clr_pent", 32'(bus.pht_entry_o),  1);

    // Random traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      bus.lookup_pc_i     = 32'($urandom_range(0, 1023)) << 2;
      bus.upd_valid_i     = ($urandom_range(0, 3) != 0);
      bus.upd_is_br_i     = ($urandom_range(0, 3) != 0);
      bus.upd_pc_i        = 32'($urandom_range(0, 1023)) << 2;
      bus.upd_taken_i     = 1'($urandom);
      bus.upd_target_i    = $urandom;
      bus.upd_pht_index_i = 8'($urandom);
      bus.upd_mispred_i   = 1'($urandom);
      reset               = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.upd_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
